// File: rtl/pix_stretch_pkg.sv
// rtl/pix_stretch_pkg.sv - shared constants, state encoding and helpers for the pixel stretcher
package pix_stretch_pkg;

    localparam logic MODE_HOLD = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Ceiling log2 with a fixed loop bound so it also maps to hardware.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Largest power of two not above value; a value of 0 gives 1.
    function automatic int pow2_floor(input int value);
        int r;
        r = 1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) <= value) begin
                r = 1 << i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pix_stretch_ch.sv
// rtl/pix_stretch_ch.sv - one colour channel: group accumulator, averaging shifter and held output
module pix_stretch_ch
    import pix_stretch_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ACC_W  = 8,
    parameter int SH_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_take,
    input  logic              i_first,
    input  logic              i_last,
    input  logic              i_mode,
    input  logic [SH_W-1:0]   i_sh,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_sum;

    // The first pixel of a group replaces whatever a discarded partial group left behind.
    assign w_ext = ACC_W'(i_data);
    assign w_sum = i_first ? w_ext : (r_acc + w_ext);

    // Accumulate accepted pixels and register the group result for the selected mode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            o_data <= '0;
        end else if (i_take) begin
            r_acc <= w_sum;
            if (i_mode == MODE_HOLD) begin
                if (i_first) begin
                    o_data <= i_data;
                end
            end else if (i_last) begin
                o_data <= DATA_W'(w_sum >> i_sh);
            end
        end
    end

endmodule

// File: rtl/pix_stretcher_mc.sv
// rtl/pix_stretcher_mc.sv - multi-channel horizontal pixel stretcher (HOLD / box-average)
module pix_stretcher_mc
    import pix_stretch_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 4,
    parameter int MAX_FACTOR = 16,
    parameter int DEF_FACTOR = 10,
    localparam int CNT_W     = clog2(MAX_FACTOR) + 1,
    localparam int ACC_W     = DATA_W + clog2(MAX_FACTOR)
) (
    input  logic                     clk_25mhz,
    input  logic                     rst_n,
    input  logic                     line_end,
    input  logic                     frame_end,
    input  logic                     de_enable,
    input  logic [CNT_W-1:0]         factor,
    input  logic                     mode,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic                     out_valid
);

    localparam int DEF_CL = (DEF_FACTOR < 1) ? 1 :
                            ((DEF_FACTOR > MAX_FACTOR) ? MAX_FACTOR : DEF_FACTOR);
    localparam logic [CNT_W-1:0] DEF_Q = CNT_W'(DEF_CL);
    localparam logic [CNT_W-1:0] MAX_Q = CNT_W'(MAX_FACTOR);

    state_t           r_state;
    logic [CNT_W-1:0] r_factor_q;
    logic             r_mode_q;
    logic [CNT_W-1:0] r_ph;
    logic             r_out_valid;

    logic [CNT_W-1:0] w_f_eff;
    logic [CNT_W-1:0] w_sh;
    logic [CNT_W-1:0] w_ph;
    logic             w_take;
    logic             w_first;
    logic             w_last;

    function automatic logic [CNT_W-1:0] clamp_factor(input logic [CNT_W-1:0] f);
        if (f == '0) begin
            return CNT_W'(1);
        end else if (f > MAX_Q) begin
            return MAX_Q;
        end
        return f;
    endfunction

    // Averaging needs a power-of-two group so the divide is a shift; HOLD uses the factor as is.
    assign w_f_eff = (r_mode_q == MODE_AVG) ? CNT_W'(pow2_floor(int'(r_factor_q))) : r_factor_q;
    assign w_sh    = CNT_W'(clog2(int'(w_f_eff)));
    assign w_ph    = (r_state == ST_IDLE) ? '0 : r_ph;

    // Boundary pulses take priority: a coincident DE pixel is dropped entirely.
    assign w_take  = de_enable & ~line_end & ~frame_end;
    assign w_first = (w_ph == '0);
    assign w_last  = (w_ph == (w_f_eff - CNT_W'(1)));

    // Control FSM: frame/line realignment, phase counting, settings latch and the valid strobe.
    always_ff @(posedge clk_25mhz) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ph        <= '0;
            r_factor_q  <= DEF_Q;
            r_mode_q    <= MODE_HOLD;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (frame_end) begin
                r_state    <= ST_IDLE;
                r_ph       <= '0;
                r_factor_q <= clamp_factor(factor);
                r_mode_q   <= mode;
            end else if (line_end) begin
                r_ph <= '0;
            end else if (de_enable) begin
                r_state     <= ST_ACTIVE;
                r_ph        <= w_last ? '0 : (w_ph + CNT_W'(1));
                r_out_valid <= (r_mode_q == MODE_HOLD) ? w_first : w_last;
            end
        end
    end

    assign out_valid = r_out_valid;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pix_stretch_ch #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .SH_W   (CNT_W)
        ) u_ch (
            .clk     (clk_25mhz),
            .rst_n   (rst_n),
            .i_take  (w_take),
            .i_first (w_first),
            .i_last  (w_last),
            .i_mode  (r_mode_q),
            .i_sh    (w_sh),
            .i_data  (data_in[c*DATA_W +: DATA_W]),
            .o_data  (data_out[c*DATA_W +: DATA_W])
        );
    end

endmodule
